bus_dtack_ctrl: RTL and testbench

//  m68k DTACK generator between the registered SB_IO bus pins and the top-level bus_dtack_n pin.

---
 rtl/bus_dtack_ctrl_if.sv | 23 ++
 rtl/bus_dtack_ctrl.sv | 179 +++++++++++++++++
 tb/tb_bus_dtack_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_dtack_ctrl_if.sv
// Bus-side handshake bundle for bus_dtack_ctrl.
// slave  : the DTACK controller (consumes CS/RW/ack, drives DTACK and strobes)
// master : the environment (registered SB_IO pins and xosera_main ack)
interface bus_dtack_ctrl_if;
    logic bus_cs_n_i;     // registered chip select, active low
    logic bus_rd_nwr_i;   // registered R/W: 1 = read, 0 = write
    logic bus_ack_i;      // read data valid strobe from xosera_main
    logic bus_dtack_n_o;  // DTACK to pin, active low
    logic dout_le_o;      // 1-clk clock enable for the bus data-out register
    logic busy_o;         // controller not idle
    logic abort_o;        // 1-clk pulse: CS released before DTACK
    logic timeout_o;      // 1-clk pulse: read forced by timeout

    modport slave (
        input  bus_cs_n_i, bus_rd_nwr_i, bus_ack_i,
        output bus_dtack_n_o, dout_le_o, busy_o, abort_o, timeout_o
    );

    modport master (
        output bus_cs_n_i, bus_rd_nwr_i, bus_ack_i,
        input  bus_dtack_n_o, dout_le_o, busy_o, abort_o, timeout_o
    );
endinterface

// File: rtl/bus_dtack_ctrl.sv
// m68k DTACK generator between the registered bus pins and bus_dtack_n.
// Writes assert DTACK after a fixed settle delay; reads wait for bus_ack,
// pulse the data-out latch enable, then assert DTACK. DTACK is released
// when CS deasserts, followed by a minimum release gap (HOLD).
// Optional feature: define DTACK_TIMEOUT_EN to force DTACK on reads that
// see no bus_ack within TIMEOUT_CYC clocks (otherwise reads wait forever).
module bus_dtack_ctrl #(
    parameter int WR_DELAY    = 2,
    parameter int RELEASE_CYC = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            reset_i,
    bus_dtack_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RD_LATCH,
        ACK,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] WR_LOAD  = (WR_DELAY > 0) ? CNT_W'(WR_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYC - 1);
`ifdef DTACK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);
`endif

    // Reject parameter sets the shared counter cannot represent.
    generate
        if (RELEASE_CYC < 1 || WR_DELAY < 0 || WR_DELAY >= (1 << CNT_W) ||
            RELEASE_CYC >= (1 << CNT_W) || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_params
            $error("bus_dtack_ctrl: parameters out of range for CNT_W");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_s;
    logic             rd_l_q, rd_l_d;
    logic             dtack_n_q, dtack_n_d;
    logic             dout_le_q, dout_le_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic             timeout_q, timeout_d;

    // Single-flop resample of CS; every decision below uses cs_s.
    // NOTE: async reset in the sensitivity list so no pulse survives a reset in any state.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) cs_s <= 1'b1;
        else         cs_s <= bus.bus_cs_n_i;
    end

    // State, counter and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_l_q    <= 1'b0;
            dtack_n_q <= 1'b1;
            dout_le_q <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_l_q    <= rd_l_d;
            dtack_n_q <= dtack_n_d;
            dout_le_q <= dout_le_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-output decode.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_l_d    = rd_l_q;
        dtack_n_d = dtack_n_q;
        dout_le_d = 1'b0;
        abort_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Level-sensitive: a CS that fell during HOLD is served here.
                if (!cs_s) begin
                    rd_l_d = bus.bus_rd_nwr_i;
                    if (bus.bus_rd_nwr_i) begin
                        state_d = RD_WAIT;
                        cnt_d   = '0;
                    end else if (WR_DELAY == 0) begin
                        state_d   = ACK;
                        dtack_n_d = 1'b0;
                    end else begin
                        state_d = WR_WAIT;
                        cnt_d   = WR_LOAD;
                    end
                end
            end

            WR_WAIT: begin
                if (cs_s) begin
                    state_d = HOLD;
                    cnt_d   = REL_LOAD;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = ACK;
                    dtack_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RD_WAIT: begin
                // Abort has priority over a coincident ack.
                if (cs_s) begin
                    state_d = HOLD;
                    cnt_d   = REL_LOAD;
                    abort_d = 1'b1;
                end else if (bus.bus_ack_i && rd_l_q) begin
                    state_d   = RD_LATCH;
                    dout_le_d = 1'b1;
                end
`ifdef DTACK_TIMEOUT_EN
                else if (cnt_q >= TO_LIMIT) begin
                    state_d   = ACK;
                    dtack_n_d = 1'b0;
                    timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            RD_LATCH: begin
                // Data was captured on the previous edge; DTACK follows it.
                state_d   = ACK;
                dtack_n_d = 1'b0;
            end

            ACK: begin
                if (cs_s) begin
                    state_d   = HOLD;
                    dtack_n_d = 1'b1;
                    cnt_d     = REL_LOAD;
                end
            end

            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end

            default: begin
                state_d   = IDLE;
                dtack_n_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.bus_dtack_n_o = dtack_n_q;
    assign bus.dout_le_o     = dout_le_q;
    assign bus.busy_o        = busy_q;
    assign bus.abort_o       = abort_q;
    assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_bus_dtack_ctrl.sv
// Directed bench for bus_dtack_ctrl (WR_DELAY=2, RELEASE_CYC=2, TIMEOUT_CYC=8).
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_bus_dtack_ctrl;

    logic clk = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    bus_dtack_ctrl_if bus ();

    bus_dtack_ctrl #(
        .WR_DELAY    (2),
        .RELEASE_CYC (2),
        .TIMEOUT_CYC (8),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        int low_seen;

        reset_i          = 1'b1;
        bus.bus_cs_n_i   = 1'b1;
        bus.bus_rd_nwr_i = 1'b1;
        bus.bus_ack_i    = 1'b0;
        #12;
        check("rst_dtack",   bus.bus_dtack_n_o, 1);
        check("rst_dout_le", bus.dout_le_o,     0);
        check("rst_busy",    bus.busy_o,        0);
        check("rst_abort",   bus.abort_o,       0);
        check("rst_timeout", bus.timeout_o,     0);
        step(2);
        reset_i = 1'b0;
        step(2);

        // Write with a stray ack held high throughout.
        bus.bus_cs_n_i   = 1'b0;
        bus.bus_rd_nwr_i = 1'b0;
        bus.bus_ack_i    = 1'b1;
        step();                                   // edge k: cs_s falls
        check("wr_busy_k", bus.busy_o, 0);
        step();                                   // k+1: WR_WAIT
        check("wr_busy_k1",  bus.busy_o,        1);
        check("wr_dtack_k1", bus.bus_dtack_n_o, 1);
        step();                                   // k+2
        check("wr_dtack_k2",   bus.bus_dtack_n_o, 1);
        check("wr_stray_le_a", bus.dout_le_o,     0);
        step();                                   // k+3: ACK
        check("wr_dtack_k3",   bus.bus_dtack_n_o, 0);
        check("wr_stray_le_b", bus.dout_le_o,     0);
        bus.bus_ack_i = 1'b0;
        step(5);
        check("wr_dtack_held", bus.bus_dtack_n_o, 0);
        bus.bus_cs_n_i = 1'b1;
        step();                                   // x+1: cs_s rises
        check("wr_rel_x1", bus.bus_dtack_n_o, 0);
        step();                                   // x+2: HOLD
        check("wr_rel_x2",  bus.bus_dtack_n_o, 1);
        check("wr_hold_bz", bus.busy_o,        1);
        step();
        check("wr_hold_x3", bus.busy_o, 1);
        step();                                   // x+4: IDLE
        check("wr_idle_x4", bus.busy_o, 0);

        // Read, R/W flipped mid-cycle (must be ignored).
        bus.bus_cs_n_i   = 1'b0;
        bus.bus_rd_nwr_i = 1'b1;
        step(2);                                  // RD_WAIT
        check("rd_busy", bus.busy_o, 1);
        bus.bus_rd_nwr_i = 1'b0;
        step(2);
        check("rd_wait_le",    bus.dout_le_o,     0);
        check("rd_wait_dtack", bus.bus_dtack_n_o, 1);
        bus.bus_ack_i = 1'b1;
        step();                                   // edge m
        check("rd_le_m",    bus.dout_le_o,     1);
        check("rd_dtack_m", bus.bus_dtack_n_o, 1);
        bus.bus_ack_i = 1'b0;
        step();                                   // edge m+1
        check("rd_le_m1",    bus.dout_le_o,     0);
        check("rd_dtack_m1", bus.bus_dtack_n_o, 0);
        step(3);
        check("rd_dtack_held", bus.bus_dtack_n_o, 0);
        bus.bus_cs_n_i   = 1'b1;
        bus.bus_rd_nwr_i = 1'b1;
        step(2);
        check("rd_release", bus.bus_dtack_n_o, 1);
        step(2);
        check("rd_idle", bus.busy_o, 0);

        // Abort: CS release and ack seen by the FSM on the same edge.
        bus.bus_cs_n_i = 1'b0;
        step(2);                                  // edge e: RD_WAIT
        check("ab_busy", bus.busy_o, 1);
        bus.bus_cs_n_i = 1'b1;
        step();                                   // e+1: cs_s rises
        check("ab_abort_e1", bus.abort_o, 0);
        bus.bus_ack_i = 1'b1;
        step();                                   // e+2: abort
        check("ab_abort_e2", bus.abort_o,       1);
        check("ab_le_e2",    bus.dout_le_o,     0);
        check("ab_dtack_e2", bus.bus_dtack_n_o, 1);
        bus.bus_ack_i = 1'b0;
        step();
        check("ab_abort_e3", bus.abort_o,       0);
        check("ab_le_e3",    bus.dout_le_o,     0);
        check("ab_dtack_e3", bus.bus_dtack_n_o, 1);
        step();
        check("ab_idle", bus.busy_o, 0);

        // Back-to-back writes, second CS asserted inside HOLD.
        bus.bus_cs_n_i   = 1'b0;
        bus.bus_rd_nwr_i = 1'b0;
        step(4);
        check("b2b_first_dtack", bus.bus_dtack_n_o, 0);
        bus.bus_cs_n_i = 1'b1;
        step(2);
        check("b2b_release", bus.bus_dtack_n_o, 1);
        bus.bus_cs_n_i = 1'b0;
        gap = 0;
        while (bus.bus_dtack_n_o !== 1'b0 && gap < 50) begin
            step();
            gap++;
        end
        check("b2b_gap",     gap,      5);
        check("b2b_min_gap", gap >= 3, 1);

        // Asynchronous reset while in ACK.
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_ack_dtack", bus.bus_dtack_n_o, 1);
        check("rst_ack_busy",  bus.busy_o,        0);
        bus.bus_cs_n_i   = 1'b1;
        bus.bus_rd_nwr_i = 1'b1;
        step(2);
        reset_i = 1'b0;
        step(2);

        // Asynchronous reset during the dout_le pulse.
        bus.bus_cs_n_i = 1'b0;
        step(2);
        bus.bus_ack_i = 1'b1;
        step();
        check("rst_le_pre", bus.dout_le_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_le_cut",   bus.dout_le_o,     0);
        check("rst_le_dtack", bus.bus_dtack_n_o, 1);
        check("rst_le_busy",  bus.busy_o,        0);
        bus.bus_ack_i  = 1'b0;
        bus.bus_cs_n_i = 1'b1;
        step(2);
        reset_i = 1'b0;
        step(2);
        check("rst_le_after", bus.dout_le_o + bus.busy_o + bus.abort_o, 0);

        // Read with no ack: timeout or indefinite wait.
        bus.bus_cs_n_i   = 1'b0;
        bus.bus_rd_nwr_i = 1'b1;
        step(2);                                  // RD_WAIT entry edge
        check("to_busy", bus.busy_o, 1);
`ifdef DTACK_TIMEOUT_EN
        step(8);
        check("to_dtack_8",   bus.bus_dtack_n_o, 1);
        check("to_pulse_8",   bus.timeout_o,     0);
        step();
        check("to_dtack_9",   bus.bus_dtack_n_o, 0);
        check("to_pulse_9",   bus.timeout_o,     1);
        check("to_le_9",      bus.dout_le_o,     0);
        step();
        check("to_pulse_10",  bus.timeout_o,     0);
        check("to_dtack_10",  bus.bus_dtack_n_o, 0);
`else
        low_seen = 0;
        repeat (1000) begin
            step();
            if (bus.bus_dtack_n_o !== 1'b1) low_seen++;
        end
        check("nto_dtack_low", low_seen,      0);
        check("nto_busy",      bus.busy_o,    1);
        check("nto_timeout",   bus.timeout_o, 0);
`endif
        bus.bus_cs_n_i = 1'b1;
        step(5);
        check("end_idle", bus.busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
